// File: rtl/connect4_pkg.sv
// Shared Connect4 encodings: game FSM state, game status, LED display FSM state.
package connect4_pkg;

  typedef enum logic [1:0] {
    GAME_INIT = 2'b00,
    P1_TURN   = 2'b01,
    P2_TURN   = 2'b10,
    END_GAME  = 2'b11
  } game_state_e;

  typedef enum logic [1:0] {
    STILL_PLAYING = 2'b00,
    P1_WINS       = 2'b01,
    P2_WINS       = 2'b10,
    TIE           = 2'b11
  } game_status_e;

  typedef enum logic [1:0] {
    D_IDLE  = 2'b00,
    D_TURN  = 2'b01,
    D_SWEEP = 2'b10,
    D_BLINK = 2'b11
  } disp_state_e;

  // Snapshot of the controller outputs that select the display mode.
  typedef struct packed {
    game_state_e  state;
    game_status_e status;
  } game_in_t;

  // Display mode selected by a controller snapshot; a win passes through the sweep only when enabled.
  function automatic disp_state_e decode_mode(input game_in_t in, input logic sweep_en);
    disp_state_e mode;
    mode = D_IDLE;
    case (in.state)
      GAME_INIT: mode = D_IDLE;
      P1_TURN,
      P2_TURN:   mode = D_TURN;
      default: begin
        case (in.status)
          P1_WINS,
          P2_WINS: mode = sweep_en ? D_SWEEP : D_BLINK;
          TIE:     mode = D_BLINK;
          default: mode = D_IDLE;  // END_GAME with no result stays dark
        endcase
      end
    endcase
    return mode;
  endfunction

endpackage

// File: rtl/tick_divider.sv
// Free-running 0..DIV-1 prescaler; tick is high while the count sits at DIV-1.
module tick_divider #(
  parameter int unsigned DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] count_q;

  assign tick = (count_q == CW'(DIV - 1));

  // Count up, wrap after DIV-1, restart from zero on clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (clear || tick) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + CW'(1);
    end
  end

endmodule

// File: rtl/game_status_leds.sv
// LED status bar driven by the Connect4 controller: turn marker, blinking
// winner/tie indication and, with GAME_STATUS_SWEEP_EN defined, a victory
// sweep ahead of the winner blink. All outputs are registered.
module game_status_leds
  import connect4_pkg::*;
#(
  parameter int unsigned NUM_LEDS  = 8,
  parameter int unsigned BLINK_DIV = 25_000_000,
  parameter int unsigned SWEEP_DIV = 6_250_000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          state,
  input  logic [1:0]          game_status,
  output logic [NUM_LEDS-1:0] LEDs
);

  localparam int unsigned P1_IDX = NUM_LEDS / 2 - 1;
  localparam int unsigned P2_IDX = NUM_LEDS / 2;

`ifdef GAME_STATUS_SWEEP_EN
  localparam logic SWEEP_EN = 1'b1;
  localparam int unsigned PW = $clog2(NUM_LEDS);
`else
  // SWEEP_DIV has no effect in this build.
  localparam logic SWEEP_EN = 1'b0 && (SWEEP_DIV >= 1);
`endif

  game_in_t              live_c;
  game_in_t              stored_q;
  logic                  mode_entry_c;
  disp_state_e           disp_q, disp_d;
  logic                  phase_q, phase_d;
  logic [NUM_LEDS-1:0]   leds_d;
  logic [NUM_LEDS-1:0]   blink_target_c;
  logic                  blink_tick;
  logic                  blink_clear_c;

  assign live_c       = '{state: game_state_e'(state), status: game_status_e'(game_status)};
  assign mode_entry_c = (live_c != stored_q);

  // Blink prescaler runs only while blinking; held at zero otherwise.
  assign blink_clear_c = mode_entry_c || (disp_q != D_BLINK);

  tick_divider #(.DIV(BLINK_DIV)) u_blink_div (
    .clk   (clk),
    .reset (reset),
    .clear (blink_clear_c),
    .tick  (blink_tick)
  );

`ifdef GAME_STATUS_SWEEP_EN
  logic [PW-1:0] pos_q, pos_d;
  logic [PW-1:0] sweep_last_c;
  logic          sweep_tick;
  logic          sweep_clear_c;

  assign sweep_clear_c = mode_entry_c || (disp_q != D_SWEEP);

  tick_divider #(.DIV(SWEEP_DIV)) u_sweep_div (
    .clk   (clk),
    .reset (reset),
    .clear (sweep_clear_c),
    .tick  (sweep_tick)
  );

  // P1 sweeps down toward LED 0, P2 sweeps up toward the top LED.
  assign sweep_last_c = (live_c.status == P1_WINS) ? '0 : PW'(NUM_LEDS - 1);
`endif

  // LED(s) lit during the ON half of the blink.
  always_comb begin
    blink_target_c = '0;
    case (live_c.status)
      P1_WINS: blink_target_c = NUM_LEDS'(1);
      P2_WINS: blink_target_c = NUM_LEDS'(1) << (NUM_LEDS - 1);
      TIE:     blink_target_c = '1;
      default: blink_target_c = '0;
    endcase
  end

  // Next display state, blink phase, sweep position and LED pattern.
  always_comb begin
    disp_d  = disp_q;
    phase_d = phase_q;
    leds_d  = '0;
`ifdef GAME_STATUS_SWEEP_EN
    pos_d   = pos_q;
`endif

    if (mode_entry_c) begin
      disp_d  = decode_mode(live_c, SWEEP_EN);
      phase_d = 1'b1;
`ifdef GAME_STATUS_SWEEP_EN
      pos_d   = (live_c.status == P1_WINS) ? PW'(NUM_LEDS - 1) : '0;
`endif
    end else begin
      case (disp_q)
`ifdef GAME_STATUS_SWEEP_EN
        D_SWEEP: begin
          if (sweep_tick) begin
            if (pos_q == sweep_last_c) begin
              disp_d  = D_BLINK;
              phase_d = 1'b1;
            end else if (live_c.status == P1_WINS) begin
              pos_d = pos_q - PW'(1);
            end else begin
              pos_d = pos_q + PW'(1);
            end
          end
        end
`endif
        D_BLINK: begin
          if (blink_tick) begin
            phase_d = ~phase_q;
          end
        end
        default: ;
      endcase
    end

    case (disp_d)
      D_TURN: begin
        if (live_c.state == P1_TURN) begin
          leds_d = NUM_LEDS'(1) << P1_IDX;
        end else begin
          leds_d = NUM_LEDS'(1) << P2_IDX;
        end
      end
`ifdef GAME_STATUS_SWEEP_EN
      D_SWEEP: leds_d = NUM_LEDS'(1) << pos_d;
`endif
      D_BLINK: leds_d = phase_d ? blink_target_c : '0;
      default: leds_d = '0;
    endcase
  end

  // State, input snapshot and LED output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stored_q <= '{state: GAME_INIT, status: STILL_PLAYING};
      disp_q   <= D_IDLE;
      phase_q  <= 1'b1;
      LEDs     <= '0;
`ifdef GAME_STATUS_SWEEP_EN
      pos_q    <= '0;
`endif
    end else begin
      stored_q <= live_c;
      disp_q   <= disp_d;
      phase_q  <= phase_d;
      LEDs     <= leds_d;
`ifdef GAME_STATUS_SWEEP_EN
      pos_q    <= pos_d;
`endif
    end
  end

endmodule

// File: tb/tb_game_status_leds.sv
// Bench for game_status_leds (NUM_LEDS=8, BLINK_DIV=4, SWEEP_DIV=2).
// Honors GAME_STATUS_SWEEP_EN the same way the design does.
module tb_game_status_leds;

  localparam int N  = 8;
  localparam int BD = 4;
  localparam int SD = 2;
`ifdef GAME_STATUS_SWEEP_EN
  localparam bit SWEEP = 1'b1;
`else
  localparam bit SWEEP = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   st;
  logic [1:0]   gs;
  logic [N-1:0] leds;

  int tests = 0;
  int fails = 0;

  // Reference: last accepted inputs and cycles elapsed since they were accepted.
  logic [1:0] m_st, m_gs;
  int         m_t;

  typedef struct {
    logic [1:0]   st;
    logic [1:0]   gs;
    logic [N-1:0] exp;
    string        name;
  } vec_t;

  vec_t vq[$];

  always #5 clk = ~clk;

  game_status_leds #(
    .NUM_LEDS  (N),
    .BLINK_DIV (BD),
    .SWEEP_DIV (SD)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .state       (st),
    .game_status (gs),
    .LEDs        (leds)
  );

  // Expected bar t cycles after the inputs were taken, from the display rules.
  function automatic logic [N-1:0] model_leds(input logic [1:0] s, input logic [1:0] g, input int t);
    logic [N-1:0] tgt;
    int           bt;
    if (s == 2'd0) return '0;
    if (s == 2'd1) return N'(1) << (N/2 - 1);
    if (s == 2'd2) return N'(1) << (N/2);
    if (g == 2'd0) return '0;
    if (g == 2'd3)      tgt = '1;
    else if (g == 2'd1) tgt = N'(1);
    else                tgt = N'(1) << (N - 1);
    bt = t;
    if (SWEEP && g != 2'd3) begin
      if (t < N * SD) begin
        if (g == 2'd2) return N'(1) << (t / SD);
        return N'(1) << (N - 1 - t / SD);
      end
      bt = t - N * SD;
    end
    return (((bt / BD) % 2) == 0) ? tgt : '0;
  endfunction

  task automatic model_reset();
    m_st = 2'd0;
    m_gs = 2'd0;
    m_t  = 0;
  endtask

  // One clock: the model takes the inputs present at the edge; sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    if ({st, gs} != {m_st, m_gs}) begin
      m_st = st;
      m_gs = gs;
      m_t  = 0;
    end else begin
      m_t++;
    end
    #1;
  endtask

  task automatic check(input string name, input logic [N-1:0] exp);
    tests++;
    if (leds !== exp) begin
      fails++;
      $display("FAIL %s: LEDs=%b expected %b (t=%0d)", name, leds, exp, $time);
    end
  endtask

  function automatic void add(input logic [1:0] s, input logic [1:0] g, input logic [N-1:0] e, input string nm);
    vec_t v;
    v.st = s; v.gs = g; v.exp = e; v.name = nm;
    vq.push_back(v);
  endfunction

  function automatic logic [N-1:0] blink(input logic [N-1:0] tgt, input int i);
    return (((i / BD) % 2) == 0) ? tgt : '0;
  endfunction

  initial begin
    // Per-cycle table: turn markers, tie blink, P2 win, P1 win.
    add(2'd1, 2'd0, 8'h08, "p1_turn");
    add(2'd2, 2'd0, 8'h10, "p2_turn");
    add(2'd2, 2'd0, 8'h10, "p2_turn_hold");
    for (int i = 0; i < 12; i++) add(2'd3, 2'd3, blink(8'hFF, i), "tie_blink");
    add(2'd0, 2'd0, 8'h00, "game_init");
    if (SWEEP) begin
      for (int i = 0; i < 16; i++) add(2'd3, 2'd2, N'(1) << (i / 2), "p2_sweep");
    end
    for (int i = 0; i < 12; i++) add(2'd3, 2'd2, blink(8'h80, i), "p2_blink");
    if (SWEEP) begin
      for (int i = 0; i < 16; i++) add(2'd3, 2'd1, N'(1) << (7 - i / 2), "p1_sweep");
    end
    for (int i = 0; i < 12; i++) add(2'd3, 2'd1, blink(8'h01, i), "p1_blink");

    reset = 1'b1;
    st    = 2'd0;
    gs    = 2'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 8'h00);
    @(negedge clk);
    reset = 1'b0;

    foreach (vq[i]) begin
      st = vq[i].st;
      gs = vq[i].gs;
      step();
      check(vq[i].name, vq[i].exp);
    end

    // P1 win interrupted after five cycles, then restarted.
    st = 2'd0; gs = 2'd0;
    step();
    check("pre_abort_idle", 8'h00);
    st = 2'd3; gs = 2'd1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("p1_before_abort", SWEEP ? (N'(1) << (7 - i / 2)) : blink(8'h01, i));
    end
    st = 2'd0; gs = 2'd0;
    step();
    check("abort_dark", 8'h00);
    st = 2'd3; gs = 2'd1;
    step();
    check("p1_restart", SWEEP ? 8'h80 : 8'h01);
    step();
    check("p1_restart_hold", SWEEP ? 8'h80 : 8'h01);

    // Asynchronous reset mid-blink, then END_GAME with no result.
    st = 2'd3; gs = 2'd3;
    step();
    check("tie_before_reset", 8'hFF);
    step();
    check("tie_before_reset2", 8'hFF);
    #3;
    reset = 1'b1;
    #1;
    check("async_reset", 8'h00);
    model_reset();
    st = 2'd3; gs = 2'd0;
    @(posedge clk);
    #1;
    check("reset_held", 8'h00);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      check("illegal_dark", 8'h00);
    end

    // Random input changes against the reference model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 23) == 0) begin
        st = 2'($urandom);
        gs = 2'($urandom);
      end
      step();
      check("random", model_leds(m_st, m_gs, m_t));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/game_status_leds.md
# game_status_leds

Parametrised successor to the game's LED status display. It drives a configurable-width LED bar from the Connect4 controller's `state` and `game_status` codes. It adds timed behaviour the purely combinational display lacked: a blinking winner/tie indication, and an optional victory sweep animation. It sits between the game FSM and the board LED pins, and all of its outputs are registered.

## Interface
- `NUM_LEDS`, default 8: LED bar width; must be even and ≥ 2.
- `BLINK_DIV`, default 25_000_000: clock cycles per blink half-period; must be ≥ 1.
- `SWEEP_DIV`, default 6_250_000: clock cycles each LED is lit during the sweep; must be ≥ 1.

Ports:
- `clk` input 1: system clock; the block uses this single clock only.
- `reset` input 1: asynchronous, active-high.
- `state` input 2: game FSM state. GAME_INIT=00, P1_TURN=01, P2_TURN=10, END_GAME=11.
- `game_status` input 2: STILL_PLAYING=00, P1_WINS=01, P2_WINS=10, TIE=11.
- `LEDs` output NUM_LEDS: LED drive; 1 = lit.

## Operation
- Display FSM states: `D_IDLE`, `D_TURN`, `D_SWEEP`, `D_BLINK`.
- Mode is decoded from the sampled `{state, game_status}`:
  - GAME_INIT → `D_IDLE`, all LEDs off.
  - P1_TURN → `D_TURN`, steady one-hot at index NUM_LEDS/2-1.
  - P2_TURN → `D_TURN`, steady one-hot at index NUM_LEDS/2.
  - END_GAME + P1_WINS → `D_SWEEP` (if enabled) then `D_BLINK`. The blink target is LED 0.
  - END_GAME + P2_WINS → same as P1_WINS, but the blink target is LED NUM_LEDS-1.
  - END_GAME + TIE → `D_BLINK`, all LEDs blink together.
  - END_GAME + STILL_PLAYING → `D_IDLE`, all off. This is an illegal combination and must stay dark.
- The block holds a registered copy of `{state, game_status}`. Any change in that copy is a mode entry, which:
  - clears the prescaler and the sweep position;
  - sets the blink phase to ON;
  - selects the new mode at that same edge.
- Blink:
  - The prescaler counts 0..BLINK_DIV-1.
  - At the edge where it equals BLINK_DIV-1, it wraps to 0 and the phase toggles.
  - Pattern: ON = target lit; OFF = all dark.
- Sweep:
  - P1_WINS: one-hot position starts at NUM_LEDS-1 and decrements toward 0.
  - P2_WINS: position starts at 0 and increments toward NUM_LEDS-1.
  - Each position is held SWEEP_DIV cycles.
  - After the last position's hold, the FSM enters `D_BLINK` with phase ON and prescaler 0.
- Counters are sized as $clog2 of their divisor, with a minimum width of 1. The position counter is $clog2(NUM_LEDS) bits. Nothing wraps outside its defined range.

## Timing
- Reset value: `LEDs` = 0, FSM = `D_IDLE`, stored inputs = 00/00, prescaler = 0, position = 0, phase = ON.
- Latency: 1 clock. New inputs present before edge k are reflected on `LEDs` after edge k.
- Blink period: exactly 2·BLINK_DIV cycles, with an ON half first.
- Sweep duration: exactly NUM_LEDS·SWEEP_DIV cycles before the first blink-ON cycle.
- Input change mid-sweep or mid-blink: the block aborts and enters the new mode at the next edge. No residual pattern carries over.
- Reset asserted at any time: all registers return to reset values immediately (asynchronously). After deassertion, the stored inputs 00/00 are compared against the live inputs as usual.
- Inputs are glitch-free, synchronous to `clk`, from the game FSM. No synchroniser is included.

## Configuration
- `GAME_STATUS_SWEEP_EN` defined: win entries pass through `D_SWEEP` as above.
- Not defined:
  - `D_SWEEP` and the position counter are not compiled.
  - Win entries go directly to `D_BLINK` with phase ON.
  - `SWEEP_DIV` is accepted but ignored.

## Structure
- Shared package `connect4_pkg` holds:
  - the state encodings (GAME_INIT, P1_TURN, P2_TURN, END_GAME);
  - the game_status encodings (STILL_PLAYING, P1_WINS, P2_WINS, TIE);
  - the display FSM state typedef.
- Sub-module `tick_divider` (parameter DIV, inputs `clk`/`reset`/`clear`, output `tick` pulsing at count DIV-1). It is instantiated once for blink and once for sweep (the latter under the macro).

## Test plan
All scenarios use NUM_LEDS=8, BLINK_DIV=4, SWEEP_DIV=2.

1. Reset then P1_TURN → LEDs = 8'b00001000 one cycle later. Switching to P2_TURN → 8'b00010000 the next cycle.
2. END_GAME+TIE → LEDs = 8'hFF for 4 cycles, 8'h00 for 4 cycles, repeating; period 8.
3. END_GAME+P2_WINS with sweep enabled → 8'h01, 8'h02, …, 8'h80, each held 2 cycles (16 cycles total), then 8'h80/8'h00 blinking with 4/4 cycles.
4. END_GAME+P1_WINS with the macro undefined → immediate 8'h01/8'h00 blink, 4/4 cycles.
5. P1_WINS sweep interrupted at cycle 5 by GAME_INIT → LEDs = 0 the next cycle. Re-entering P1_WINS restarts at 8'h80.
6. `reset` asserted mid-blink, between edges → LEDs = 0 asynchronously. END_GAME+STILL_PLAYING → LEDs stay 0.
